// File: rtl/pipelined_ready_fifo.sv
// pipelined_ready_fifo
//   Purpose : circular-buffer FIFO feeding a registered first-word-fall-through
//             output stage, with a credit-style ready sent back upstream.
//   Latency : a write in cycle N is visible on dataOut/dataOutValid in cycle N+2
//             (one cycle into memory, one cycle memory -> output register).
//   Backpressure: writeEn cannot be stalled. readyForInput drops while free
//             space is no longer larger than READY_LATENCY, so that a sender
//             honouring the pipe delay never overruns. A write that still
//             arrives while full (and not popping) is dropped and sets the
//             sticky overflow flag.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   writeEn, dataIn write strobe and data from the upstream delay pipe
//   readyForInput   registered credit back to the sender
//   dataOut, dataOutValid, dataOutReady  registered head word and its handshake
//   overflow        sticky "a write was dropped"
//   occupancy       words held, memory plus output register
module pipelined_ready_fifo #(
  parameter int WIDTH         = 32,
  parameter int DEPTH_LOG2    = 5,
  parameter int READY_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEn,
  input  logic [WIDTH-1:0]      dataIn,
  output logic                  readyForInput,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  dataOutValid,
  input  logic                  dataOutReady,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   occupancy
);

  localparam int              DEPTH   = 1 << DEPTH_LOG2;
  localparam int              CW      = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   LAT_C   = CW'(READY_LATENCY);

  // Storage. The output register counts toward DEPTH, so the memory never
  // holds more than DEPTH-1 words; the write slot is therefore always free.
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic                  out_vld_q, out_vld_d;
  logic [WIDTH-1:0]      out_dat_q, out_dat_d;
  logic                  ovf_q, ovf_d;
  logic                  rdy_q, rdy_d;

  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic                  mem_has_data;
  logic                  load_out;

  // Handshake decode. Everything is gated by rst so inputs are ignored while
  // the block is being reset.
  always_comb begin
    pop          = ~rst & out_vld_q & dataOutReady;
    full         = (occ_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a write at full is accepted.
    push         = ~rst & writeEn & (~full | pop);
    drop         = ~rst & writeEn & full & ~pop;
    // Words in memory = occupancy minus the one held in the output register.
    mem_has_data = (occ_q > CW'(out_vld_q));
    // Refill the output register whenever it is empty or being emptied; this
    // is what gives one pop per cycle while data is available.
    load_out     = ~rst & mem_has_data & (~out_vld_q | pop);
  end

  // Next-state computation for all registered state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    ovf_d     = ovf_q;
    rdy_d     = rdy_q;

    if (rst) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      occ_d     = '0;
      out_vld_d = 1'b0;
      ovf_d     = 1'b0;
      rdy_d     = 1'b0;
    end else begin
      // Pointers wrap naturally at 2^DEPTH_LOG2.
      if (push) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (load_out) begin
        rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
        out_dat_d = mem_q[rd_ptr_q];
      end
      out_vld_d = load_out | (out_vld_q & ~pop);

      unique case ({push, pop})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase

      ovf_d = ovf_q | drop;
      // Credit reflects the occupancy that will be visible next cycle.
      // occ_d never exceeds DEPTH, so the subtraction cannot wrap.
      rdy_d = ((DEPTH_C - occ_d) > LAT_C);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q  <= wr_ptr_d;
    rd_ptr_q  <= rd_ptr_d;
    occ_q     <= occ_d;
    out_vld_q <= out_vld_d;
    out_dat_q <= out_dat_d;
    ovf_q     <= ovf_d;
    rdy_q     <= rdy_d;
  end

  // Memory array: no reset, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  assign readyForInput = rdy_q;
  assign dataOut       = out_dat_q;
  assign dataOutValid  = out_vld_q;
  assign overflow      = ovf_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_pipelined_ready_fifo.sv
module tb_pipelined_ready_fifo;
  localparam int WIDTH = 32;
  localparam int DL2   = 5;
  localparam int RL    = 4;
  localparam int DEPTH = 1 << DL2;

  logic             clk = 1'b0;
  logic             rst;
  logic             writeEn;
  logic [WIDTH-1:0] dataIn;
  logic             readyForInput;
  logic [WIDTH-1:0] dataOut;
  logic             dataOutValid;
  logic             dataOutReady;
  logic             overflow;
  logic [DL2:0]     occupancy;

  always #5 clk = ~clk;

  pipelined_ready_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2), .READY_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .writeEn(writeEn), .dataIn(dataIn),
    .readyForInput(readyForInput), .dataOut(dataOut), .dataOutValid(dataOutValid),
    .dataOutReady(dataOutReady), .overflow(overflow), .occupancy(occupancy)
  );

  // Reference model: queue of accepted words tagged with their push cycle.
  // A word is presentable once it is at the head and at least two cycles old.
  typedef struct { logic [WIDTH-1:0] d; int t; } ent_t;
  ent_t mq[$];
  int   cyc = 0;
  bit   m_ovf = 0;
  bit   m_rdy = 0;
  bit   started = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].t <= cyc - 2);
  endfunction

  // Model update at each active edge from the inputs of the ending cycle.
  always @(posedge clk) begin : model
    bit v, p, pu;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_rdy = 0;
    end else begin
      v  = m_valid();
      p  = v && dataOutReady;
      pu = writeEn && ((mq.size() < DEPTH) || p);
      if (p)  void'(mq.pop_front());
      if (pu) mq.push_back('{dataIn, cyc});
      if (writeEn && !pu) m_ovf = 1;
      m_rdy = ((DEPTH - mq.size()) > RL);
    end
    cyc++;
    started = 1;
  end

  // Compare process: all outputs against the model, every cycle, mid-cycle.
  always @(negedge clk) begin : compare
    bit v;
    if (started) begin
      v = m_valid();
      chk("valid", dataOutValid, v);
      if (v) chk("data", dataOut, mq[0].d);
      chk("occupancy", occupancy, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("ready", readyForInput, m_rdy);
    end
  end

  // Drive one cycle of inputs, return at the next mid-cycle point.
  task automatic step(input logic we, input logic [WIDTH-1:0] d, input logic rdy);
    writeEn      = we;
    dataIn       = d;
    dataOutReady = rdy;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  task automatic fill(input int n, input logic [WIDTH-1:0] base);
    for (int i = 1; i <= n; i++) step(1'b1, base + WIDTH'(i), 1'b0);
  endtask

  bit rhist[$];

  initial begin
    rst = 1'b1; writeEn = 1'b0; dataIn = '0; dataOutReady = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1111_1111, 1'b1);
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", dataOutValid, 0);
    chk("rst_ready", readyForInput, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("ready_after_rst", readyForInput, 1);
    step(1'b0, '0, 1'b0);

    // Single word latency: visible exactly two cycles after the write
    step(1'b1, 32'hA5A5_A5A5, 1'b1);
    chk("lat_n1_valid", dataOutValid, 0);
    chk("lat_n1_occ", occupancy, 1);
    step(1'b0, '0, 1'b1);
    chk("lat_n2_valid", dataOutValid, 1);
    chk("lat_n2_data", dataOut, 32'hA5A5_A5A5);
    step(1'b0, '0, 1'b1);
    chk("lat_n3_valid", dataOutValid, 0);
    chk("lat_n3_occ", occupancy, 0);

    // Fill to full with no pops; credit falls when free space reaches RL
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 32'h1000 + k, 1'b0);
      chk("fill_occ", occupancy, k);
      chk("fill_ready", readyForInput, (DEPTH - k) > RL);
    end
    chk("fill_ovf", overflow, 0);

    // Extra write at full is dropped
    step(1'b1, 32'hDEAD, 1'b0);
    chk("drop_ovf", overflow, 1);
    chk("drop_occ", occupancy, DEPTH);
    chk("drop_head", dataOut, 32'h1001);
    drain(DEPTH + 8);
    chk("drop_drained", occupancy, 0);
    chk("ovf_sticky", overflow, 1);

    rst = 1'b1; step(1'b0, '0, 1'b0); rst = 1'b0; step(1'b0, '0, 1'b0);
    chk("ovf_cleared", overflow, 0);

    // Full-rate push and pop at full for 100 cycles
    fill(DEPTH, 32'h2000);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 32'h3000 + i, 1'b1);
      chk("stream_occ", occupancy, DEPTH);
    end
    chk("stream_head", dataOut, 32'h3044);
    chk("stream_ovf", overflow, 0);
    drain(DEPTH + 8);

    // Reset mid-operation
    fill(17, 32'h4000);
    chk("pre_rst_occ", occupancy, 17);
    rst = 1'b1; step(1'b0, '0, 1'b1); rst = 1'b0;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_valid", dataOutValid, 0);
    step(1'b0, '0, 1'b0);
    chk("mid_rst_ready", readyForInput, 1);
    step(1'b1, 32'hBEEF, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("post_rst_valid", dataOutValid, 1);
    chk("post_rst_data", dataOut, 32'hBEEF);
    drain(4);

    // Random traffic; sender acts on readyForInput as seen RL cycles ago
    rhist.delete();
    for (int i = 0; i < 3000; i++) begin
      bit allow, we, rd;
      int pr;
      rhist.push_back(readyForInput);
      allow = (rhist.size() > RL) ? rhist[rhist.size() - 1 - RL] : 1'b0;
      pr    = (i < 1000) ? 20 : ((i < 2000) ? 50 : 85);
      we    = allow && ($urandom_range(0, 99) < 80);
      rd    = ($urandom_range(0, 99) < pr);
      step(we, $urandom, rd);
    end
    drain(DEPTH + 8);
    chk("rand_ovf", overflow, 0);
    chk("rand_empty", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
